// File: rtl/rr_lock_arbiter_pkg.sv
// Shared definitions for the round-robin lock arbiter: FSM encoding and
// default parameter values.
package rr_lock_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_ID_W     = 2;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/rr_lock_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request searching from
// ptr upward, wrapping modulo N.
module rr_pick
    import rr_lock_arbiter_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int ID_W = DEF_ID_W
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    winner,
    output logic [ID_W-1:0] winner_id,
    output logic            any
);

    logic [N-1:0] rot;
    int           first_k;
    int           win_idx;

    // Duplicating req makes the rotate a plain right shift; bit k of rot is
    // requester (ptr + k) mod N.
    assign rot = N'({req, req} >> ptr);
    assign any = |rot;

    always_comb begin
        first_k = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                first_k = k;
            end
        end
        win_idx = int'(ptr) + first_k;
        if (win_idx >= N) begin
            win_idx = win_idx - N;
        end
    end

    assign winner_id = ID_W'(win_idx);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign winner[gi] = any && (win_idx == gi);
        end
    endgenerate

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin lock arbiter: grants are held until release, request drop or
// hold timeout, with a one-cycle bubble between owners.
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int ID_W     = DEF_ID_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    rel,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id,
    output logic            timeout
);

    localparam bit               TO_EN     = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N - 1);

    state_t            state_reg, state_next;
    logic [N-1:0]      gnt_reg, gnt_next;
    logic              gnt_valid_reg, gnt_valid_next;
    logic [ID_W-1:0]   gnt_id_reg, gnt_id_next;
    logic              timeout_reg, timeout_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [CNT_W-1:0]  hold_cnt_reg, hold_cnt_next;

    logic [N-1:0]      pick_winner;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;

    logic              owner_rel;
    logic              owner_req;
    logic              hold_expired;
    logic              busy_exit;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_reg),
        .winner    (pick_winner),
        .winner_id (pick_id),
        .any       (pick_any)
    );

    // Masking with the registered grant honours only the owner's bits and
    // ignores rel in the cycle the grant is being issued.
    assign owner_rel    = |(rel & gnt_reg);
    assign owner_req    = |(req & gnt_reg);
    assign hold_expired = TO_EN && (hold_cnt_reg == HOLD_LAST);
    assign busy_exit    = owner_rel || !owner_req || hold_expired;

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_valid_next = gnt_valid_reg;
        gnt_id_next    = gnt_id_reg;
        timeout_next   = 1'b0;
        ptr_next       = ptr_reg;
        hold_cnt_next  = hold_cnt_reg;

        case (state_reg)
            IDLE, GAP: begin
                if (pick_any) begin
                    state_next     = BUSY;
                    gnt_next       = pick_winner;
                    gnt_valid_next = 1'b1;
                    gnt_id_next    = pick_id;
                    hold_cnt_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (busy_exit) begin
                    state_next     = GAP;
                    gnt_next       = '0;
                    gnt_valid_next = 1'b0;
                    ptr_next       = (gnt_id_reg == LAST_ID) ? '0 : gnt_id_reg + ID_W'(1);
                    timeout_next   = hold_expired && !owner_rel && owner_req;
                end else if (hold_cnt_reg != '1) begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next     = IDLE;
                gnt_next       = '0;
                gnt_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_id_reg    <= '0;
            timeout_reg   <= 1'b0;
            ptr_reg       <= '0;
            hold_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
            gnt_id_reg    <= gnt_id_next;
            timeout_reg   <= timeout_next;
            ptr_reg       <= ptr_next;
            hold_cnt_reg  <= hold_cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign gnt_id    = gnt_id_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter; expected grants are queued by the
// stimulus and checked by a monitor at each grant's end.
module tb_rr_lock_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;
    logic [3:0] rel = 4'b0000;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    always #5 clk = ~clk;

    rr_lock_arbiter #(
        .N        (4),
        .ID_W     (2),
        .CNT_W    (8),
        .MAX_HOLD (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    typedef struct {
        int id;
        int len;
        int to;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    logic rst_q = 1'b0;

    bit prev_valid = 1'b0;
    int cur_id = 0;
    int run_len = 0;
    int gap_cnt = 0;
    int gap_seen = 0;

    always @(posedge clk) rst_q <= rst;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("queue_empty", exp_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (rst_q) begin
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_valid", int'(gnt_valid), 0);
            chk("rst_id", int'(gnt_id), 0);
            chk("rst_timeout", int'(timeout), 0);
            prev_valid = 1'b0;
            gap_cnt    = 0;
        end else begin
            chk("valid_is_or", int'(gnt_valid), int'(|gnt));
            chk("onehot0", int'($onehot0(gnt)), 1);
            if (gnt_valid) begin
                chk("gnt_matches_id", int'(gnt), 1 << gnt_id);
                chk("no_timeout_while_gnt", int'(timeout), 0);
            end
            if (gnt_valid && !prev_valid) begin
                cur_id   = int'(gnt_id);
                run_len  = 1;
                gap_seen = gap_cnt;
            end else if (gnt_valid) begin
                chk("owner_stable", int'(gnt_id), cur_id);
                run_len++;
            end else if (prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant id=%0d len=%0d", cur_id, run_len);
                end else begin
                    e = exp_q.pop_front();
                    $display("grant id=%0d len=%0d timeout=%0d gap=%0d (expect id=%0d len=%0d timeout=%0d gap=%0d)",
                             cur_id, run_len, timeout, gap_seen, e.id, e.len, e.to, e.gap);
                    chk("grant_id", cur_id, e.id);
                    chk("grant_len", run_len, e.len);
                    chk("timeout_pulse", int'(timeout), e.to);
                    if (e.gap >= 0) chk("gap_cycles", gap_seen, e.gap);
                end
                gap_cnt = 1;
            end else begin
                chk("no_timeout_idle", int'(timeout), 0);
                gap_cnt++;
            end
            prev_valid = gnt_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int len, input int to, input int gap);
        exp_t x;
        x.id = id; x.len = len; x.to = to; x.gap = gap;
        exp_q.push_back(x);
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 40 && !gnt_valid; i++) tick(1);
        if (!gnt_valid) begin
            $display("FAIL wait_grant no grant within 40 cycles");
            $fatal;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && gnt_valid; i++) tick(1);
        if (gnt_valid) begin
            $display("FAIL wait_idle grant still held after 40 cycles");
            $fatal;
        end
    endtask

    // Owner idx pulses rel so that the grant lasts exactly k cycles.
    task automatic rel_after(input int idx, input int k, input logic [3:0] req_after);
        wait_grant();
        if (k > 1) tick(k - 1);
        rel = 4'(1 << idx);
        tick(1);
        rel = 4'b0000;
        req = req_after;
    endtask

    initial begin
        tick(2);
        rst = 1'b0;

        push(0, 3, 0, -1);
        push(1, 3, 0, 1);
        push(2, 3, 0, 1);
        push(3, 3, 0, 1);
        push(0, 3, 0, 1);
        rel_after(0, 3, 4'b1111);
        rel_after(1, 3, 4'b1111);
        rel_after(2, 3, 4'b1111);
        rel_after(3, 3, 4'b1111);
        rel_after(0, 3, 4'b0000);
        tick(2);

        push(2, 16, 1, -1);
        push(2, 16, 0, 1);
        req = 4'b0100;
        wait_grant();
        wait_idle();
        rel_after(2, 16, 4'b0000);
        tick(2);

        push(2, 5, 0, -1);
        req = 4'b0100;
        wait_grant();
        tick(1);
        rel = 4'b0010;
        tick(1);
        rel = 4'b0000;
        tick(2);
        req = 4'b0000;
        tick(3);

        push(0, 2, 0, -1);
        push(1, 4, 0, 1);
        req = 4'b0011;
        rel_after(0, 2, 4'b0011);
        rel_after(1, 4, 4'b0000);
        tick(2);

        push(3, 3, 0, -1);
        push(3, 2, 0, 1);
        req = 4'b1000;
        rel = 4'b1000;
        tick(1);
        rel = 4'b0000;
        rel_after(3, 3, 4'b1000);
        rel_after(3, 2, 4'b0000);
        tick(2);

        req = 4'b0010;
        wait_grant();
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        req = 4'b0000;
        tick(3);

        push(0, 1, 0, -1);
        req = 4'b1111;
        rel_after(0, 1, 4'b0000);
        tick(3);
        done = 1'b1;
    end

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal;
    end

endmodule
